// File: rtl/fp_accel_pkg.sv
// Shared definitions for the fingerprint accelerator datapath.
package fp_accel_pkg;

  // Default fingerprint vector width and the number of bus words per vector.
  localparam int DEF_VECTOR_WIDTH = 920;
  localparam int WORDS_PER_VEC    = 2;

  // Word phase: waiting for the FULL word, or for the PAD word of a vector.
  typedef enum logic {
    EXP_FIRST  = 1'b0,
    EXP_SECOND = 1'b1
  } phase_e;

  // Width needed to hold a bit count from 0 up to vecWidth inclusive.
  function automatic int calcCntWidth(input int vecWidth);
    return $clog2(vecWidth + 1);
  endfunction

  localparam int CNT_WIDTH = calcCntWidth(DEF_VECTOR_WIDTH);

endpackage

// File: rtl/chunk_popcnt.sv
// Combinational population count of one CHUNK_WIDTH-bit slice.
module chunk_popcnt #(
  parameter int CHUNK_WIDTH = 64
) (
  input  logic [CHUNK_WIDTH-1:0]           i_Data,
  output logic [$clog2(CHUNK_WIDTH+1)-1:0] o_Count
);

  localparam int POP_W = $clog2(CHUNK_WIDTH + 1);

  // Add up every bit of the slice.
  always_comb begin
    o_Count = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      o_Count = o_Count + POP_W'(i_Data[i]);
    end
  end

endmodule

// File: rtl/vec_bit_cnt.sv
// Counts the 1 bits of two-word fingerprint vectors in a 3-stage pipeline:
// chunk popcounts, word sum, then per-vector accumulation and outputs.
module vec_bit_cnt
  import fp_accel_pkg::*;
#(
  parameter int BUS_WIDTH    = 512,
  parameter int VECTOR_WIDTH = 920,
  parameter int VEC_ID_WIDTH = 8,
  parameter int CHUNK_WIDTH  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [BUS_WIDTH-1:0]                   i_Vector,
  input  logic [VEC_ID_WIDTH-1:0]                i_VecID,
  input  logic                                   i_Valid,
  output logic [calcCntWidth(VECTOR_WIDTH)-1:0]  o_Count,
  output logic [VEC_ID_WIDTH-1:0]                o_VecID,
  output logic                                   o_Valid,
  output logic                                   o_Error
);

  localparam int CNT_W      = calcCntWidth(VECTOR_WIDTH);
  localparam int NUM_CHUNKS = BUS_WIDTH / CHUNK_WIDTH;
  localparam int POP_W      = $clog2(CHUNK_WIDTH + 1);
  localparam int SUM_W      = $clog2(BUS_WIDTH + 1);

  // Input phase tracking
  phase_e                              r_Phase;
  logic [VEC_ID_WIDTH-1:0]             r_CurId;
  logic                                w_IsLast;
  logic                                w_IsAbort;

  // Stage 1: chunk popcounts
  logic [NUM_CHUNKS-1:0][POP_W-1:0]    w_ChunkPop;
  logic [NUM_CHUNKS-1:0][POP_W-1:0]    r_S1Pop;
  logic                                r_S1Valid;
  logic                                r_S1Last;
  logic                                r_S1Abort;
  logic [VEC_ID_WIDTH-1:0]             r_S1Id;

  // Stage 2: word sum
  logic [SUM_W-1:0]                    w_WordSum;
  logic [SUM_W-1:0]                    r_S2Sum;
  logic                                r_S2Valid;
  logic                                r_S2Last;
  logic                                r_S2Abort;
  logic [VEC_ID_WIDTH-1:0]             r_S2Id;

  // Stage 3: accumulator for the FULL word count
  logic [CNT_W-1:0]                    r_Acc;

  // Classify the incoming word: PAD of the open vector, or a restart with a new ID.
  always_comb begin
    w_IsLast  = (r_Phase == EXP_SECOND) && (i_VecID == r_CurId);
    w_IsAbort = (r_Phase == EXP_SECOND) && (i_VecID != r_CurId);
  end

  // Phase and open-vector ID; any word that is not a matching PAD starts a new vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_Phase <= EXP_FIRST;
      r_CurId <= '0;
    end else if (i_Valid) begin
      if (w_IsLast) begin
        r_Phase <= EXP_FIRST;
      end else begin
        r_Phase <= EXP_SECOND;
        r_CurId <= i_VecID;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    chunk_popcnt #(
      .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_chunkPopcnt (
      .i_Data  (i_Vector[g*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .o_Count (w_ChunkPop[g])
    );
  end

  // Stage 1 register: chunk counts plus the word's tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_S1Valid <= 1'b0;
    end else begin
      r_S1Valid <= i_Valid;
      r_S1Last  <= w_IsLast;
      r_S1Abort <= w_IsAbort;
      r_S1Id    <= i_VecID;
      r_S1Pop   <= w_ChunkPop;
    end
  end

  // Sum the chunk counts into one word count.
  always_comb begin
    w_WordSum = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      w_WordSum = w_WordSum + SUM_W'(r_S1Pop[i]);
    end
  end

  // Stage 2 register: word count plus tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_S2Valid <= 1'b0;
    end else begin
      r_S2Valid <= r_S1Valid;
      r_S2Last  <= r_S1Last;
      r_S2Abort <= r_S1Abort;
      r_S2Id    <= r_S1Id;
      r_S2Sum   <= w_WordSum;
    end
  end

  // Stage 3: hold the FULL word count, emit the total on the PAD word, flag restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_Acc   <= '0;
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      o_Count <= '0;
      o_VecID <= '0;
    end else begin
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      if (r_S2Valid) begin
        if (r_S2Last) begin
          o_Valid <= 1'b1;
          o_Count <= r_Acc + CNT_W'(r_S2Sum);
          o_VecID <= r_S2Id;
        end else begin
          r_Acc   <= CNT_W'(r_S2Sum);
          o_Error <= r_S2Abort;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_bit_cnt.sv
// Self-checking bench for vec_bit_cnt: directed table, corner sequences and
// random traffic against a word-level reference model.
module tb_vec_bit_cnt;

  localparam int BW   = 512;
  localparam int VW   = 920;
  localparam int IDW  = 8;
  localparam int CW   = 64;
  localparam int CNTW = $clog2(VW + 1);
  localparam logic [BW-1:0] PAD_MASK = (BW'(1) << 408) - BW'(1);

  logic            clk = 1'b0;
  logic            rst;
  logic [BW-1:0]   i_Vector;
  logic [IDW-1:0]  i_VecID;
  logic            i_Valid;
  logic [CNTW-1:0] o_Count;
  logic [IDW-1:0]  o_VecID;
  logic            o_Valid;
  logic            o_Error;

  vec_bit_cnt #(
    .BUS_WIDTH    (BW),
    .VECTOR_WIDTH (VW),
    .VEC_ID_WIDTH (IDW),
    .CHUNK_WIDTH  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_Vector (i_Vector),
    .i_VecID  (i_VecID),
    .i_Valid  (i_Valid),
    .o_Count  (o_Count),
    .o_VecID  (o_VecID),
    .o_Valid  (o_Valid),
    .o_Error  (o_Error)
  );

  always #5 clk = ~clk;

  // Expected output events, ordered by the edge at which they must appear
  typedef struct {
    int             outEdge;
    bit             isErr;
    int             cnt;
    logic [IDW-1:0] id;
  } outEvt_t;

  typedef struct {
    logic [BW-1:0]  word0;
    logic [BW-1:0]  word1;
    logic [IDW-1:0] id;
    int             expCount;
  } vecRec_t;

  outEvt_t        pending[$];
  int             validEdges[$];
  int             errEdges[$];
  int             edgeNum = 0;
  bit             mExpSecond = 1'b0;
  logic [IDW-1:0] mCurId = '0;
  int             mPart = 0;
  int             mHeldCnt = 0;
  logic [IDW-1:0] mHeldId = '0;
  int             lastCount = 0;
  logic [IDW-1:0] lastId = '0;
  int             nVectors = 0;
  int             nMiscompares = 0;

  function automatic logic [BW-1:0] randWord();
    logic [BW-1:0] w;
    for (int i = 0; i < BW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [BW-1:0] onesLow(input int n);
    logic [BW-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = 1'b1;
    return w;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeNum);
    end
  endtask

  task automatic checkOutput(input bit expValid, input bit expError);
    compareVal("o_Valid", 32'(o_Valid), 32'(expValid));
    compareVal("o_Error", 32'(o_Error), 32'(expError));
    compareVal("o_Count", 32'(o_Count), 32'(mHeldCnt));
    compareVal("o_VecID", 32'(o_VecID), 32'(mHeldId));
    if (o_Valid === 1'b1) begin
      validEdges.push_back(edgeNum);
      lastCount = int'(o_Count);
      lastId    = o_VecID;
    end
    if (o_Error === 1'b1) errEdges.push_back(edgeNum);
  endtask

  // Drive one cycle, advance the reference model at the edge, then check outputs.
  task automatic applyStimulus(input bit rstV, input bit validV,
                               input logic [BW-1:0] vec, input logic [IDW-1:0] id);
    bit      expValid;
    bit      expError;
    outEvt_t ev;
    int      pop;
    rst      = rstV;
    i_Valid  = validV;
    i_Vector = vec;
    i_VecID  = id;
    @(posedge clk);
    edgeNum++;
    expValid = 1'b0;
    expError = 1'b0;
    if (rstV) begin
      pending.delete();
      mExpSecond = 1'b0;
      mHeldCnt   = 0;
      mHeldId    = '0;
    end else begin
      if (pending.size() > 0 && pending[0].outEdge == edgeNum) begin
        ev = pending.pop_front();
        if (ev.isErr) begin
          expError = 1'b1;
        end else begin
          expValid = 1'b1;
          mHeldCnt = ev.cnt;
          mHeldId  = ev.id;
        end
      end
      if (validV) begin
        pop = $countones(vec);
        if (!mExpSecond) begin
          mPart      = pop;
          mCurId     = id;
          mExpSecond = 1'b1;
        end else if (id == mCurId) begin
          pending.push_back('{outEdge: edgeNum + 2, isErr: 1'b0, cnt: mPart + pop, id: id});
          mExpSecond = 1'b0;
        end else begin
          pending.push_back('{outEdge: edgeNum + 2, isErr: 1'b1, cnt: 0, id: id});
          mPart  = pop;
          mCurId = id;
        end
      end
    end
    #1;
    checkOutput(expValid, expError);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, randWord(), IDW'($urandom));
  endtask

  initial begin
    vecRec_t vecTable[3];
    int      padEdge;
    logic [BW-1:0]  rv;
    logic [IDW-1:0] rid;
    bit             rrst;
    bit             rval;

    vecTable[0] = '{word0: '1,           word1: PAD_MASK,     id: 8'h05, expCount: 920};
    vecTable[1] = '{word0: '0,           word1: '0,           id: 8'hFF, expCount: 0};
    vecTable[2] = '{word0: onesLow(10),  word1: onesLow(5),   id: 8'h3C, expCount: 15};

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, randWord(), 8'h11);
    applyStimulus(1'b1, 1'b1, randWord(), 8'h11);
    compareVal("resetCount", 32'(o_Count), 32'd0);
    compareVal("resetValid", 32'(o_Valid), 32'd0);

    $display("[TB] table vectors");
    for (int t = 0; t < 3; t++) begin
      validEdges.delete();
      applyStimulus(1'b0, 1'b1, vecTable[t].word0, vecTable[t].id);
      applyStimulus(1'b0, 1'b1, vecTable[t].word1, vecTable[t].id);
      padEdge = edgeNum;
      idle(4);
      compareVal("tablePulses", 32'(validEdges.size()), 32'd1);
      compareVal("tableTiming", (validEdges.size() > 0) ? 32'(validEdges[0]) : 32'hFFFF_FFFF, 32'(padEdge + 2));
      compareVal("tableCount", 32'(lastCount), 32'(vecTable[t].expCount));
      compareVal("tableId", 32'(lastId), 32'(vecTable[t].id));
    end

    $display("[TB] streaming");
    validEdges.delete();
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, 1'b1, randWord(), IDW'(v));
      applyStimulus(1'b0, 1'b1, randWord() & PAD_MASK, IDW'(v));
    end
    idle(4);
    compareVal("streamPulses", 32'(validEdges.size()), 32'd4);
    compareVal("streamSpan", (validEdges.size() == 4) ? 32'(validEdges[3] - validEdges[0]) : 32'hFFFF_FFFF, 32'd6);

    $display("[TB] gap between words");
    validEdges.delete();
    applyStimulus(1'b0, 1'b1, onesLow(300), 8'h42);
    idle(3);
    applyStimulus(1'b0, 1'b1, onesLow(100), 8'h42);
    padEdge = edgeNum;
    idle(4);
    compareVal("gapPulses", 32'(validEdges.size()), 32'd1);
    compareVal("gapTiming", (validEdges.size() > 0) ? 32'(validEdges[0]) : 32'hFFFF_FFFF, 32'(padEdge + 2));
    compareVal("gapCount", 32'(lastCount), 32'd400);

    $display("[TB] ID change");
    validEdges.delete();
    errEdges.delete();
    applyStimulus(1'b0, 1'b1, randWord(), 8'h07);
    applyStimulus(1'b0, 1'b1, onesLow(10), 8'h08);
    applyStimulus(1'b0, 1'b1, onesLow(5), 8'h08);
    idle(4);
    compareVal("abortErrors", 32'(errEdges.size()), 32'd1);
    compareVal("abortPulses", 32'(validEdges.size()), 32'd1);
    compareVal("abortCount", 32'(lastCount), 32'd15);
    compareVal("abortId", 32'(lastId), 32'h08);

    $display("[TB] reset mid-stream");
    validEdges.delete();
    errEdges.delete();
    applyStimulus(1'b0, 1'b1, onesLow(50), 8'h11);
    applyStimulus(1'b0, 1'b1, onesLow(60), 8'h11);
    applyStimulus(1'b1, 1'b0, randWord(), 8'h11);
    compareVal("rstMidCount", 32'(o_Count), 32'd0);
    compareVal("rstMidId", 32'(o_VecID), 32'd0);
    idle(4);
    compareVal("rstMidPulses", 32'(validEdges.size() + errEdges.size()), 32'd0);
    applyStimulus(1'b0, 1'b1, onesLow(33), 8'h22);
    applyStimulus(1'b0, 1'b1, onesLow(44), 8'h22);
    idle(4);
    compareVal("rstNextPulses", 32'(validEdges.size()), 32'd1);
    compareVal("rstNextCount", 32'(lastCount), 32'd77);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      rrst = ($urandom_range(99) == 0);
      rval = ($urandom_range(9) < 7);
      if (mExpSecond && $urandom_range(9) < 8) rid = mCurId;
      else rid = IDW'($urandom_range(3));
      rv = randWord() & PAD_MASK;
      applyStimulus(rrst, rval, rv, rid);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
